mul_share_arbiter: RTL and testbench
====================================

// Module: mul_share_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer that shares one 64x64->128 multiplier among
//  N_REQ factorial cores. It latches the granted core's operands and drives the
//  multiplier start/clear/done handshake. It returns the 128-bit product with a
//  one-cycle done pulse to the owner, and aborts on a watchdog timeout.
//  It sits between the factorial cores and the single multiplier instance.
// PARAMETERS
//  N_REQ    2    number of requesting cores (2..8)
//  W        64   operand width; product is 2*W
//  TIMEOUT  255  max cycles in BUSY waiting for m_done before abort (>=1)
// PORTS
//  clk       in   1        system clock, rising edge
//  reset_n   in   1        asynchronous active-low reset
//  req       in   N_REQ    per-core multiply request (level)
//  req_a     in   N_REQ*W  operand A, core i at [i*W +: W]
//  req_b     in   N_REQ*W  operand B, core i at [i*W +: W]
//  grant     out  N_REQ    one-hot owner of multiplier, held during BUSY and RESP
//  rsp_done  out  N_REQ    one-cycle pulse to owner: product valid
//  rsp_err   out  N_REQ    one-cycle pulse to owner: timeout abort
//  rsp_result out 2*W      last product; held until next RESP
//  m_start   out  1        multiplier start (level, held in BUSY)
//  m_clear   out  1        multiplier clear (high in IDLE/RESP/ABORT)
//  m_a, m_b  out  W        latched operands to multiplier
//  m_done    in   1        multiplier completion
//  m_result  in   2*W      multiplier product
// BEHAVIOUR
//  Reset (async): state=IDLE, ptr=0, grant=0, rsp_done=0, rsp_err=0, rsp_result=0,
//   m_start=0, m_clear=1, m_a=m_b=0, wdog=0. All outputs are registered.
//  FSM: IDLE -> BUSY -> RESP -> IDLE; BUSY -> ABORT -> IDLE on timeout.
//  IDLE: m_clear=1, m_start=0. If |req, pick the first set req at or after ptr,
//   wrapping modulo N_REQ. On that edge: grant<=onehot(owner), m_a/m_b<=owner's
//   operands, m_start<=1, m_clear<=0, wdog<=0, go to BUSY. Latency req->m_start:
//   1 cycle.
//  BUSY: m_start is held at 1 and wdog increments each cycle. Operand or req changes
//   are ignored. Withdrawing req does not cancel the operation.
//  m_done=1 in BUSY: rsp_result<=m_result, rsp_done[owner]<=1, m_start<=0,
//   m_clear<=1, ptr<=(owner+1)%N_REQ, go to RESP. rsp_done comes 1 cycle after
//   m_done.
//  wdog==TIMEOUT without m_done: rsp_err[owner]<=1, m_start<=0, m_clear<=1,
//   rsp_result unchanged, ptr<=(owner+1)%N_REQ, go to ABORT.
//  m_done on the same cycle as wdog==TIMEOUT: completion wins, no error.
//  RESP/ABORT: last 1 cycle. The pulse clears and grant<=0, then return to IDLE.
//   The owner drops req in this cycle. A req still high in the next IDLE is a new
//   request.
//  m_done outside BUSY is ignored.
//  Fairness: after any grant, the previous owner has lowest priority. No core waits
//   more than N_REQ-1 operations.
//  Reset mid-operation: immediate return to reset values. No done/err pulse; the
//   product is lost.
// TESTING
//  T1 single: req=01, a=5, b=7, multiplier done 3 cycles after start ->
//     m_start at +1, rsp_done=01 pulse, rsp_result=35, grant=01 then 00.
//  T2 contention: req=11 held, ptr=0 -> grant sequence 01,10,01,10.
//     Each core is served alternately.
//  T3 withdraw: core1 drops req 1 cycle into BUSY -> op completes,
//     rsp_done=10 still pulses.
//  T4 timeout: m_done never asserted, TIMEOUT=4 -> rsp_err pulse 4 cycles after
//     grant. m_clear=1, rsp_result unchanged, next grant goes to other core.
//  T5 tie: m_done on the wdog==TIMEOUT cycle -> rsp_done, not rsp_err.
//  T6 reset: reset_n low during BUSY -> all outputs at reset values at once.
//     The next req is granted from ptr=0.

Source files
------------

// File: rtl/mul_share_arbiter_if.sv
// Bus between the multiplier-sharing arbiter, the factorial cores and the
// shared 64x64->128 multiplier.
//   master : arbiter view (drives grant/response and multiplier controls)
//   slave  : environment view (cores + multiplier drive requests/completion)
// Signals:
//   req/req_a/req_b      per-core request and operands (core i at [i*W +: W])
//   grant                one-hot owner of the multiplier
//   rsp_done/rsp_err     one-cycle result / timeout pulses to the owner
//   rsp_result           last product
//   m_start/m_clear      multiplier handshake controls
//   m_a/m_b              latched operands to the multiplier
//   m_done/m_result      multiplier completion and product
interface mul_share_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int W     = 64
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   rsp_done;
  logic [N_REQ-1:0]   rsp_err;
  logic [2*W-1:0]     rsp_result;
  logic               m_start;
  logic               m_clear;
  logic [W-1:0]       m_a;
  logic [W-1:0]       m_b;
  logic               m_done;
  logic [2*W-1:0]     m_result;

  modport master (
    input  req, req_a, req_b, m_done, m_result,
    output grant, rsp_done, rsp_err, rsp_result, m_start, m_clear, m_a, m_b
  );

  modport slave (
    output req, req_a, req_b, m_done, m_result,
    input  grant, rsp_done, rsp_err, rsp_result, m_start, m_clear, m_a, m_b
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter and sequencer sharing one 64x64->128 multiplier among
// N_REQ factorial cores. Latches the winner's operands, drives the multiplier
// start/clear handshake, returns the product with a one-cycle done pulse and
// aborts with an error pulse when the multiplier does not finish in time.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      mul_share_arbiter_if.master (core requests/responses, multiplier)
//
// state   | meaning
// S_IDLE  | multiplier cleared, waiting for any request
// S_BUSY  | owner's operation running, m_start held, watchdog counting
// S_RESP  | rsp_done pulse to owner, grant still held
// S_ABORT | rsp_err pulse to owner after watchdog expiry, grant still held
module mul_share_arbiter #(
  parameter int N_REQ   = 2,
  parameter int W       = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mul_share_arbiter_if.master  bus
);

  localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP,
    S_ABORT
  } state_t;

  state_t           state_q, state_nxt;
  logic [PW-1:0]    ptr_q, ptr_nxt;
  logic [PW-1:0]    owner_q, owner_nxt;
  logic [N_REQ-1:0] grant_q, grant_nxt;
  logic [N_REQ-1:0] rsp_done_q, rsp_done_nxt;
  logic [N_REQ-1:0] rsp_err_q, rsp_err_nxt;
  logic [2*W-1:0]   rsp_result_q, rsp_result_nxt;
  logic             m_start_q, m_start_nxt;
  logic             m_clear_q, m_clear_nxt;
  logic [W-1:0]     m_a_q, m_a_nxt;
  logic [W-1:0]     m_b_q, m_b_nxt;
  // Watchdog as a down-counter: loaded with TIMEOUT-1 on grant so BUSY lasts
  // at most TIMEOUT cycles; expiry is the terminal count of zero.
  logic [WDW-1:0]   wdog_q, wdog_nxt;

  logic             pick_found;
  logic [PW-1:0]    pick_idx;
  logic [PW-1:0]    ptr_after_owner;

  // First requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_found && bus.req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(idx);
      end
    end
  end

  // The finishing owner drops to lowest priority.
  assign ptr_after_owner = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_nxt      = state_q;
    ptr_nxt        = ptr_q;
    owner_nxt      = owner_q;
    grant_nxt      = grant_q;
    rsp_done_nxt   = '0;
    rsp_err_nxt    = '0;
    rsp_result_nxt = rsp_result_q;
    m_start_nxt    = m_start_q;
    m_clear_nxt    = m_clear_q;
    m_a_nxt        = m_a_q;
    m_b_nxt        = m_b_q;
    wdog_nxt       = wdog_q;

    unique case (state_q)
      S_IDLE: begin
        m_start_nxt = 1'b0;
        m_clear_nxt = 1'b1;
        if (pick_found) begin
          owner_nxt   = pick_idx;
          grant_nxt   = N_REQ'(1) << pick_idx;
          m_a_nxt     = bus.req_a[pick_idx*W +: W];
          m_b_nxt     = bus.req_b[pick_idx*W +: W];
          m_start_nxt = 1'b1;
          m_clear_nxt = 1'b0;
          wdog_nxt    = WDW'(TIMEOUT - 1);
          state_nxt   = S_BUSY;
        end
      end

      S_BUSY: begin
        // Completion is tested first so it wins over a simultaneous expiry.
        if (bus.m_done) begin
          rsp_result_nxt         = bus.m_result;
          rsp_done_nxt[owner_q]  = 1'b1;
          m_start_nxt            = 1'b0;
          m_clear_nxt            = 1'b1;
          ptr_nxt                = ptr_after_owner;
          state_nxt              = S_RESP;
        end else if (wdog_q == '0) begin
          rsp_err_nxt[owner_q]   = 1'b1;
          m_start_nxt            = 1'b0;
          m_clear_nxt            = 1'b1;
          ptr_nxt                = ptr_after_owner;
          state_nxt              = S_ABORT;
        end else begin
          wdog_nxt = wdog_q - 1'b1;
        end
      end

      S_RESP, S_ABORT: begin
        grant_nxt = '0;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      grant_q      <= '0;
      rsp_done_q   <= '0;
      rsp_err_q    <= '0;
      rsp_result_q <= '0;
      m_start_q    <= 1'b0;
      m_clear_q    <= 1'b1;
      m_a_q        <= '0;
      m_b_q        <= '0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_nxt;
      ptr_q        <= ptr_nxt;
      owner_q      <= owner_nxt;
      grant_q      <= grant_nxt;
      rsp_done_q   <= rsp_done_nxt;
      rsp_err_q    <= rsp_err_nxt;
      rsp_result_q <= rsp_result_nxt;
      m_start_q    <= m_start_nxt;
      m_clear_q    <= m_clear_nxt;
      m_a_q        <= m_a_nxt;
      m_b_q        <= m_b_nxt;
      wdog_q       <= wdog_nxt;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.rsp_done   = rsp_done_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.m_start    = m_start_q;
  assign bus.m_clear    = m_clear_q;
  assign bus.m_a        = m_a_q;
  assign bus.m_b        = m_b_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with two cores, 64-bit operands and a
// watchdog of 4 cycles. The bench plays both the cores and the multiplier.
module tb_mul_share_arbiter;
  localparam int N  = 2;
  localparam int W  = 64;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mul_share_arbiter_if #(.N_REQ(N), .W(W)) bus ();

  mul_share_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [63:0] a0, input logic [63:0] b0,
                         input logic [63:0] a1, input logic [63:0] b1);
    bus.req_a = {a1, a0};
    bus.req_b = {b1, b0};
  endtask

  // Grant edge, `delay` busy cycles, then m_done; checks grant, response, release.
  task automatic serve(input string tag, input logic [1:0] exp_grant,
                       input logic [63:0] exp_a, input logic [63:0] exp_b,
                       input logic [127:0] prod, input int delay);
    tick();
    chk({tag, "_grant"}, bus.grant, exp_grant);
    chk({tag, "_m_a"}, bus.m_a, exp_a);
    chk({tag, "_m_b"}, bus.m_b, exp_b);
    chk({tag, "_m_start"}, bus.m_start, 1'b1);
    repeat (delay) tick();
    bus.m_done   = 1'b1;
    bus.m_result = prod;
    tick();
    bus.m_done = 1'b0;
    chk({tag, "_rsp_done"}, bus.rsp_done, exp_grant);
    chk({tag, "_rsp_err"}, bus.rsp_err, 2'b00);
    chk({tag, "_rsp_result"}, bus.rsp_result, prod);
    tick();
    chk({tag, "_release"}, bus.grant, 2'b00);
    chk({tag, "_pulse_clear"}, bus.rsp_done, 2'b00);
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.req      = '0;
    bus.req_a    = '0;
    bus.req_b    = '0;
    bus.m_done   = 1'b0;
    bus.m_result = '0;
    tick();
    tick();
    chk("rst_grant", bus.grant, 2'b00);
    chk("rst_m_start", bus.m_start, 1'b0);
    chk("rst_m_clear", bus.m_clear, 1'b1);
    chk("rst_result", bus.rsp_result, 128'd0);
    chk("rst_m_a", bus.m_a, 64'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_grant", bus.grant, 2'b00);

    // T1 single request, done 3 cycles after start.
    set_ops(64'd5, 64'd7, 64'd0, 64'd0);
    bus.req = 2'b01;
    tick();
    chk("t1_m_start", bus.m_start, 1'b1);
    chk("t1_m_clear", bus.m_clear, 1'b0);
    chk("t1_grant", bus.grant, 2'b01);
    chk("t1_m_a", bus.m_a, 64'd5);
    chk("t1_m_b", bus.m_b, 64'd7);
    tick();
    tick();
    tick();
    chk("t1_no_early_done", bus.rsp_done, 2'b00);
    bus.m_done   = 1'b1;
    bus.m_result = 128'd35;
    bus.req      = 2'b00;
    tick();
    bus.m_done = 1'b0;
    chk("t1_rsp_done", bus.rsp_done, 2'b01);
    chk("t1_rsp_result", bus.rsp_result, 128'd35);
    chk("t1_grant_resp", bus.grant, 2'b01);
    chk("t1_m_clear_resp", bus.m_clear, 1'b1);
    chk("t1_m_start_resp", bus.m_start, 1'b0);
    tick();
    chk("t1_grant_idle", bus.grant, 2'b00);
    chk("t1_pulse_clear", bus.rsp_done, 2'b00);

    // T6 reset during BUSY (ptr is 1 here, so core1 wins alone anyway).
    set_ops(64'd0, 64'd0, 64'd100, 64'd200);
    bus.req = 2'b10;
    tick();
    chk("t6_grant", bus.grant, 2'b10);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_grant_rst", bus.grant, 2'b00);
    chk("t6_m_start_rst", bus.m_start, 1'b0);
    chk("t6_m_clear_rst", bus.m_clear, 1'b1);
    chk("t6_m_a_rst", bus.m_a, 64'd0);
    chk("t6_result_rst", bus.rsp_result, 128'd0);
    chk("t6_done_rst", bus.rsp_done, 2'b00);
    chk("t6_err_rst", bus.rsp_err, 2'b00);
    set_ops(64'd3, 64'd4, 64'd6, 64'd9);
    bus.req = 2'b11;
    tick();
    reset_n = 1'b1;

    // T2 contention from ptr=0: alternate 01,10,01,10.
    serve("t2_op0", 2'b01, 64'd3, 64'd4, 128'd12, 1);
    serve("t2_op1", 2'b10, 64'd6, 64'd9, 128'd54, 2);
    serve("t2_op2", 2'b01, 64'd3, 64'd4, 128'd12, 0);
    serve("t2_op3", 2'b10, 64'd6, 64'd9, 128'd54, 1);

    // T3 core1 withdraws one cycle into BUSY; operation still completes.
    set_ops(64'd3, 64'd4, 64'd11, 64'd13);
    bus.req = 2'b10;
    tick();
    chk("t3_grant", bus.grant, 2'b10);
    chk("t3_m_a", bus.m_a, 64'd11);
    tick();
    bus.req = 2'b00;
    tick();
    chk("t3_grant_held", bus.grant, 2'b10);
    chk("t3_m_start_held", bus.m_start, 1'b1);
    bus.m_done   = 1'b1;
    bus.m_result = 128'd143;
    tick();
    bus.m_done = 1'b0;
    chk("t3_rsp_done", bus.rsp_done, 2'b10);
    chk("t3_rsp_result", bus.rsp_result, 128'd143);
    tick();
    chk("t3_grant_idle", bus.grant, 2'b00);

    // m_done while idle is ignored.
    bus.m_done   = 1'b1;
    bus.m_result = 128'd999;
    tick();
    bus.m_done = 1'b0;
    chk("idle_done_ignored", bus.rsp_done, 2'b00);
    chk("idle_result_kept", bus.rsp_result, 128'd143);
    chk("idle_no_grant", bus.grant, 2'b00);

    // T4 timeout: no m_done, error pulse 4 cycles after grant.
    set_ops(64'd2, 64'd2, 64'd11, 64'd13);
    bus.req = 2'b01;
    tick();
    chk("t4_grant", bus.grant, 2'b01);
    tick();
    tick();
    tick();
    chk("t4_no_early_err", bus.rsp_err, 2'b00);
    chk("t4_m_start_last", bus.m_start, 1'b1);
    bus.req = 2'b11;
    tick();
    chk("t4_rsp_err", bus.rsp_err, 2'b01);
    chk("t4_no_done", bus.rsp_done, 2'b00);
    chk("t4_m_clear", bus.m_clear, 1'b1);
    chk("t4_m_start", bus.m_start, 1'b0);
    chk("t4_result_kept", bus.rsp_result, 128'd143);
    chk("t4_grant_abort", bus.grant, 2'b01);
    tick();
    chk("t4_err_clear", bus.rsp_err, 2'b00);
    chk("t4_grant_idle", bus.grant, 2'b00);
    tick();
    chk("t4_next_grant", bus.grant, 2'b10);

    // T5 m_done on the final watchdog cycle: completion wins.
    tick();
    tick();
    tick();
    bus.m_done   = 1'b1;
    bus.m_result = 128'h1234;
    bus.req      = 2'b00;
    tick();
    bus.m_done = 1'b0;
    chk("t5_rsp_done", bus.rsp_done, 2'b10);
    chk("t5_no_err", bus.rsp_err, 2'b00);
    chk("t5_rsp_result", bus.rsp_result, 128'h1234);
    tick();
    chk("t5_grant_idle", bus.grant, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
